// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory checker command path.
//   TRANS_CNT_W  : width of transaction counters
//   test_mode_t  : test operating mode
//   cmd_state_t  : command issuer FSM states
//   decode_mode(): maps the raw 2-bit mode input onto test_mode_t
package rtl_settings_pkg;

  localparam int TRANS_CNT_W = 16;

  typedef enum logic [1:0] {
    WRITE_ONLY = 2'd0,
    READ_ONLY  = 2'd1,
    WRITE_READ = 2'd2
  } test_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_READ,
    ST_NEXT
  } cmd_state_t;

  // Code 3 is reserved and behaves like a plain write test.
  function automatic test_mode_t decode_mode(input logic [1:0] mode_raw);
    case (mode_raw)
      2'd1:    return READ_ONLY;
      2'd2:    return WRITE_READ;
      default: return WRITE_ONLY;
    endcase
  endfunction

endpackage

// File: rtl/mem_cmd_block_if.sv
// Avalon-MM command bus between the command issuer and the memory under test.
//   amm_address     : word address of the command
//   amm_burstcount  : beats in the burst
//   amm_write       : write request
//   amm_writedata   : write beat data
//   amm_read        : read request
//   amm_waitrequest : slave stall
// master modport: command issuer side; slave modport: memory side.
interface mem_cmd_block_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]  amm_address;
  logic [BURST_W-1:0] amm_burstcount;
  logic               amm_write;
  logic [DATA_W-1:0]  amm_writedata;
  logic               amm_read;
  logic               amm_waitrequest;

  modport master (
    output amm_address, amm_burstcount, amm_write, amm_writedata, amm_read,
    input  amm_waitrequest
  );

  modport slave (
    input  amm_address, amm_burstcount, amm_write, amm_writedata, amm_read,
    output amm_waitrequest
  );
endinterface

// File: rtl/mem_cmd_block_wr_data_gen.sv
// Write data generator: every byte of the word is pattern + beat index (mod 256).
// Also used by the data checker to build expected read data.
//   pattern_i : base byte
//   beat_i    : 0-based beat index within the burst
//   data_o    : replicated DATA_W-bit word
module wr_data_gen #(
  parameter int DATA_W  = 128,
  parameter int BURST_W = 8
) (
  input  logic [7:0]         pattern_i,
  input  logic [BURST_W-1:0] beat_i,
  output logic [DATA_W-1:0]  data_o
);
  logic [7:0] byte_val;

  // Only the low 8 bits of the beat index matter for a mod-256 sum.
  assign byte_val = pattern_i + 8'(beat_i);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_byte
      assign data_o[gi*8 +: 8] = byte_val;
    end
  endgenerate
endmodule

// File: rtl/mem_cmd_block.sv
// Command issuer: takes addresses from the address generator and issues
// Avalon-MM write and/or read bursts for a programmed number of transactions.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   test_start_i       : start pulse (ignored while busy)
//   test_mode_i        : 0 write, 1 read, 2 write-then-read, 3 as write
//   trans_cnt_i        : number of transactions
//   burst_len_i        : beats per burst (0 means 1)
//   data_pattern_i     : base byte for write data
//   next_addr_i        : current address from the generator
//   next_addr_en_o     : advance-generator pulse
//   amm                : Avalon-MM master command bus
//   busy_o             : run in progress
//   trans_done_o       : one-cycle completion pulse
//   trans_cnt_o        : completed transactions
module mem_cmd_block
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int BURST_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_start_i,
  input  logic [1:0]             test_mode_i,
  input  logic [TRANS_CNT_W-1:0] trans_cnt_i,
  input  logic [BURST_W-1:0]     burst_len_i,
  input  logic [7:0]             data_pattern_i,
  input  logic [ADDR_W-1:0]      next_addr_i,
  output logic                   next_addr_en_o,
  mem_cmd_block_if.master        amm,
  output logic                   busy_o,
  output logic                   trans_done_o,
  output logic [TRANS_CNT_W-1:0] trans_cnt_o
);

  cmd_state_t             state_q, state_d;
  test_mode_t             mode_q, mode_d;
  logic [TRANS_CNT_W-1:0] total_q, total_d;
  logic [TRANS_CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic [BURST_W-1:0]     beat_q, beat_d;
  logic [7:0]             pattern_q, pattern_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_cmd, rd_cmd;
  logic                   last_txn;
  logic [DATA_W-1:0]      wdata;

  // Compare in 17 bits so a count of 65535 never sees a wrapped sum.
  assign last_txn = ({1'b0, done_cnt_q} + 17'd1) == {1'b0, total_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= WRITE_ONLY;
      total_q    <= '0;
      done_cnt_q <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      pattern_q  <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      total_q    <= total_d;
      done_cnt_q <= done_cnt_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      pattern_q  <= pattern_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    total_d        = total_q;
    done_cnt_d     = done_cnt_q;
    burst_d        = burst_q;
    beat_d         = beat_q;
    pattern_d      = pattern_q;
    addr_d         = addr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    wr_cmd         = 1'b0;
    rd_cmd         = 1'b0;
    next_addr_en_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only IDLE has busy low, so a start anywhere else is ignored.
        if (test_start_i) begin
          mode_d     = decode_mode(test_mode_i);
          total_d    = trans_cnt_i;
          burst_d    = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
          pattern_d  = data_pattern_i;
          done_cnt_d = '0;
          beat_d     = '0;
          if (trans_cnt_i == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        addr_d  = next_addr_i;
        state_d = (mode_q == READ_ONLY) ? ST_READ : ST_WRITE;
      end

      ST_WRITE: begin
        wr_cmd = 1'b1;
        if (!amm.amm_waitrequest) begin
          if (beat_q == burst_q - BURST_W'(1)) begin
            beat_d  = '0;
            state_d = (mode_q == WRITE_READ) ? ST_READ : ST_NEXT;
          end else begin
            beat_d = beat_q + BURST_W'(1);
          end
        end
      end

      ST_READ: begin
        rd_cmd = 1'b1;
        if (!amm.amm_waitrequest) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        done_cnt_d = done_cnt_q + TRANS_CNT_W'(1);
        if (last_txn) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          // Generator advances on this edge; LOAD then samples the new address.
          next_addr_en_o = 1'b1;
          state_d        = ST_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  wr_data_gen #(
    .DATA_W  (DATA_W),
    .BURST_W (BURST_W)
  ) u_wr_data_gen (
    .pattern_i (pattern_q),
    .beat_i    (beat_q),
    .data_o    (wdata)
  );

  assign amm.amm_address    = addr_q;
  assign amm.amm_burstcount = burst_q;
  assign amm.amm_write      = wr_cmd;
  assign amm.amm_read       = rd_cmd;
  assign amm.amm_writedata  = wdata;

  assign busy_o       = busy_q;
  assign trans_done_o = done_q;
  assign trans_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_mem_cmd_block.sv
module tb_mem_cmd_block;
  import rtl_settings_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 128;
  localparam int BURST_W = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               test_start_i;
  logic [1:0]         test_mode_i;
  logic [15:0]        trans_cnt_i;
  logic [BURST_W-1:0] burst_len_i;
  logic [7:0]         data_pattern_i;
  logic [ADDR_W-1:0]  next_addr_i;
  logic               next_addr_en_o;
  logic               busy_o;
  logic               trans_done_o;
  logic [15:0]        trans_cnt_o;
  logic               waitreq;

  always #5 clk_i = ~clk_i;

  mem_cmd_block_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) amm_if ();
  assign amm_if.amm_waitrequest = waitreq;

  mem_cmd_block #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .test_start_i   (test_start_i),
    .test_mode_i    (test_mode_i),
    .trans_cnt_i    (trans_cnt_i),
    .burst_len_i    (burst_len_i),
    .data_pattern_i (data_pattern_i),
    .next_addr_i    (next_addr_i),
    .next_addr_en_o (next_addr_en_o),
    .amm            (amm_if.master),
    .busy_o         (busy_o),
    .trans_done_o   (trans_done_o),
    .trans_cnt_o    (trans_cnt_o)
  );

  // Address generator model: loads base on an accepted start, steps by inc.
  logic [ADDR_W-1:0] gen_base, gen_inc, gen_addr;
  always @(posedge clk_i) begin
    if (rst_i)                        gen_addr <= '0;
    else if (test_start_i && !busy_o) gen_addr <= gen_base;
    else if (next_addr_en_o)          gen_addr <= gen_addr + gen_inc;
  end
  assign next_addr_i = gen_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          count;
    int          burst;
    logic [7:0]  pattern;
    logic [31:0] base;
    logic [31:0] inc;
    int          stall;
    bit          rnd;
    int          restart_cyc;
    int          exp_writes;
    int          exp_reads;
    int          exp_next;
    int          exp_bc;
  } vec_t;

  vec_t tbl [9];

  task automatic run_vec(input int idx, input vec_t v);
    int          writes = 0, reads = 0, nexts = 0, beat = 0, hold = 0;
    int          first_cmd = -1, done_cyc = -1;
    bit          done_seen = 0, prev_stall = 0;
    logic [7:0]  b;
    logic [127:0] exp_data;
    logic [41:0] prev_ctl = '0;
    logic [127:0] prev_data = '0;
    logic        wr, rd;
    @(negedge clk_i);
    gen_base       = v.base;
    gen_inc        = v.inc;
    test_mode_i    = v.mode;
    trans_cnt_i    = 16'(v.count);
    burst_len_i    = BURST_W'(v.burst);
    data_pattern_i = v.pattern;
    test_start_i   = 1'b1;
    waitreq        = 1'b0;
    for (int cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      test_start_i = (cyc == v.restart_cyc);
      trans_cnt_i  = (cyc == v.restart_cyc) ? 16'(v.count + 5) : 16'(v.count);
      wr = amm_if.amm_write;
      rd = amm_if.amm_read;
      chk("rd_wr_excl", {127'd0, wr & rd}, 128'd0);
      if (prev_stall) begin
        chk("stall_ctl_stable",
            {86'd0, wr, rd, amm_if.amm_burstcount, amm_if.amm_address}, {86'd0, prev_ctl});
        if (wr) chk("stall_data_stable", amm_if.amm_writedata, prev_data);
      end
      if ((wr || rd) && first_cmd < 0) first_cmd = cyc;
      if (wr || rd) begin
        hold++;
        if (v.rnd) waitreq = 1'($urandom_range(0, 1));
        else       waitreq = (hold <= v.stall);
        if (!waitreq) begin
          if (!v.rnd) chk("hold_len", 128'(hold), 128'(v.stall + 1));
          chk("addr", 128'(amm_if.amm_address), 128'(v.base + v.inc * 32'(nexts)));
          chk("burstcount", 128'(amm_if.amm_burstcount), 128'(v.exp_bc));
          if (wr) begin
            b        = v.pattern + 8'(beat);
            exp_data = {16{b}};
            chk("wdata", amm_if.amm_writedata, exp_data);
            writes++;
            beat++;
            if (beat == v.exp_bc) beat = 0;
          end else begin
            reads++;
          end
          hold = 0;
        end
      end else begin
        waitreq = 1'b0;
      end
      prev_stall = (wr || rd) && waitreq;
      prev_ctl   = {wr, rd, amm_if.amm_burstcount, amm_if.amm_address};
      prev_data  = amm_if.amm_writedata;
      if (next_addr_en_o) nexts++;
      if (trans_done_o) begin
        done_seen = 1;
        done_cyc  = cyc;
        chk("busy_at_done", 128'(busy_o), 128'd0);
        chk("trans_cnt_final", 128'(trans_cnt_o), 128'(v.count));
      end
    end
    waitreq = 1'b0;
    chk("done_seen", 128'(done_seen), 128'd1);
    chk("writes", 128'(writes), 128'(v.exp_writes));
    chk("reads", 128'(reads), 128'(v.exp_reads));
    chk("next_pulses", 128'(nexts), 128'(v.exp_next));
    if (v.count > 0) chk("start_latency", 128'(first_cmd), 128'd2);
    else             chk("zero_done_latency", 128'(done_cyc), 128'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("done_one_cycle", 128'(trans_done_o), 128'd0);
    chk("cnt_hold", 128'(trans_cnt_o), 128'(v.count));
    $display("vec %0d mode=%0d count=%0d burst=%0d writes=%0d reads=%0d next=%0d done_cyc=%0d",
             idx, v.mode, v.count, v.burst, writes, reads, nexts, done_cyc);
  endtask

  initial begin
    int  acc;
    bit  hit;
    //            mode   cnt brst pattern base      inc    stl rnd rst  wr rd nx bc
    tbl[0] = '{2'd0, 3, 2, 8'hA0, 32'h10,  32'd1, 0, 1'b0, 0,  6, 0, 2, 2};
    tbl[1] = '{2'd1, 2, 4, 8'h00, 32'h20,  32'd1, 3, 1'b0, 0,  0, 2, 1, 4};
    tbl[2] = '{2'd2, 1, 1, 8'h33, 32'h55,  32'd0, 0, 1'b0, 0,  1, 1, 0, 1};
    tbl[3] = '{2'd0, 0, 2, 8'h10, 32'h70,  32'd1, 0, 1'b0, 0,  0, 0, 0, 2};
    tbl[4] = '{2'd0, 2, 0, 8'h10, 32'h100, 32'd1, 0, 1'b0, 0,  2, 0, 1, 1};
    tbl[5] = '{2'd0, 1, 2, 8'hFF, 32'h200, 32'd1, 1, 1'b0, 0,  2, 0, 0, 2};
    tbl[6] = '{2'd3, 2, 1, 8'h5A, 32'h7,   32'd1, 0, 1'b0, 0,  2, 0, 1, 1};
    tbl[7] = '{2'd2, 4, 3, 8'h01, 32'h40,  32'd1, 0, 1'b1, 6, 12, 4, 3, 3};
    tbl[8] = '{2'd1, 3, 1, 8'h00, 32'h80,  32'd2, 0, 1'b1, 0,  0, 3, 2, 1};

    rst_i          = 1'b1;
    test_start_i   = 1'b0;
    test_mode_i    = 2'd0;
    trans_cnt_i    = '0;
    burst_len_i    = '0;
    data_pattern_i = '0;
    gen_base       = '0;
    gen_inc        = '0;
    waitreq        = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_write", 128'(amm_if.amm_write), 128'd0);
    chk("rst_read", 128'(amm_if.amm_read), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_done", 128'(trans_done_o), 128'd0);
    chk("rst_cnt", 128'(trans_cnt_o), 128'd0);
    chk("rst_next_en", 128'(next_addr_en_o), 128'd0);
    chk("rst_addr", 128'(amm_if.amm_address), 128'd0);
    chk("rst_burstcount", 128'(amm_if.amm_burstcount), 128'd0);
    chk("rst_wdata", amm_if.amm_writedata, 128'd0);
    rst_i = 1'b0;

    // Reset while beat 2 of a 4-beat write burst is on the bus.
    @(negedge clk_i);
    gen_base       = 32'h30;
    gen_inc        = 32'd1;
    test_mode_i    = 2'd0;
    trans_cnt_i    = 16'd2;
    burst_len_i    = 8'd4;
    data_pattern_i = 8'h11;
    test_start_i   = 1'b1;
    acc = 0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      test_start_i = 1'b0;
      if (amm_if.amm_write) begin
        if (acc == 2) hit = 1;
        else          acc++;
      end
    end
    chk("midburst_reached", 128'(hit), 128'd1);
    chk("beat2_data", amm_if.amm_writedata, {16{8'h13}});
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_write", 128'(amm_if.amm_write), 128'd0);
    chk("midrst_read", 128'(amm_if.amm_read), 128'd0);
    chk("midrst_busy", 128'(busy_o), 128'd0);
    chk("midrst_cnt", 128'(trans_cnt_o), 128'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);
    // Back-to-back rerun of the first vector after all others.
    run_vec(9, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
